// File: rtl/seven_seg_scan_decoder.sv
// Scan-bus monitor: rebuilds the eight BCD digits shown by a multiplexed
// active-low seven-segment driver and flags scan-order, pattern and stall faults.
module seven_seg_scan_decoder #(
  parameter int SETTLE       = 2,
  parameter int STALL_CYCLES = 1024
) (
  input  logic        i_clk,
  input  logic        i_clr,
  input  logic        i_ce,
  input  logic [6:0]  i_seg_in,
  input  logic [7:0]  i_sel_in,
  output logic [31:0] o_digits_bcd,
  output logic [7:0]  o_digit_err,
  output logic        o_frame_valid,
  output logic        o_seq_err,
  output logic        o_stall,
  output logic        o_locked
);

  localparam int SW = $clog2(STALL_CYCLES) + 1;
  localparam logic [0:0] S_SYNC = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;
  localparam logic [SW-1:0] STALL_MAX = SW'(STALL_CYCLES);

  // {err, bcd}; blank reads as E, unknown patterns as F with err set
  function automatic logic [4:0] f_decode(input logic [6:0] s);
    case (s)
      7'b1000000: f_decode = 5'h00;
      7'b1111001: f_decode = 5'h01;
      7'b0100100: f_decode = 5'h02;
      7'b0110000: f_decode = 5'h03;
      7'b0011001: f_decode = 5'h04;
      7'b0010010: f_decode = 5'h05;
      7'b0000010: f_decode = 5'h06;
      7'b1111000: f_decode = 5'h07;
      7'b0000000: f_decode = 5'h08;
      7'b0010000: f_decode = 5'h09;
      7'b1111111: f_decode = 5'h0E;
      default:    f_decode = 5'h1F;
    endcase
  endfunction

  logic [6:0]       r_seg, r_seg_p;
  logic [7:0]       r_sel, r_sel_p;
  logic [3:0]       r_settle;
  logic [SW-1:0]    r_stall_cnt;
  logic             r_stall;
  logic [0:0]       r_state;
  logic [2:0]       r_expect;
  logic [6:0][3:0]  r_shadow;
  logic [6:0]       r_shadow_err;
  logic             r_fv, r_se;

  logic             w_same, w_sel_change, w_cap, w_onecold;
  logic [3:0]       w_settle_n, w_nlow;
  logic [2:0]       w_idx;
  logic [4:0]       w_dec;
  logic [SW-1:0]    w_stall_cnt_n;
  logic             w_stall_n;
  logic [0:0]       w_state_n;
  logic [2:0]       w_expect_n;
  logic [6:0][3:0]  w_shadow_n;
  logic [6:0]       w_shadow_err_n;
  logic [31:0]      w_digits_n;
  logic [7:0]       w_derr_n;
  logic             w_fv_n, w_se_n;

  always_comb begin
    w_sel_change = (r_sel != r_sel_p);
    w_same       = !w_sel_change && (r_seg == r_seg_p);
    w_settle_n   = w_same ? ((r_settle == 4'd15) ? 4'd15 : r_settle + 4'd1) : 4'd1;
    // one capture per dwell: the step onto SETTLE, or the change itself when SETTLE is 1
    w_cap        = w_same ? (r_settle == 4'(SETTLE - 1)) : (SETTLE == 1);
    w_nlow       = 4'($countones(~r_sel));
    w_onecold    = (w_nlow == 4'd1);
    w_idx        = 3'd0;
    for (int i = 0; i < 8; i++)
      if (!r_sel[i]) w_idx = 3'(i);
    w_dec        = f_decode(r_seg);
  end

  always_comb begin
    w_state_n      = r_state;
    w_expect_n     = r_expect;
    w_shadow_n     = r_shadow;
    w_shadow_err_n = r_shadow_err;
    w_digits_n     = o_digits_bcd;
    w_derr_n       = o_digit_err;
    w_fv_n         = 1'b0;
    w_se_n         = 1'b0;
    w_stall_cnt_n  = r_stall_cnt;
    w_stall_n      = r_stall;

    if (w_cap && (r_sel != 8'hFF)) begin
      if (!w_onecold) begin
        w_se_n    = 1'b1;
        w_state_n = S_SYNC;
      end else if ((r_state == S_SYNC) || (w_idx != r_expect)) begin
        if (r_state == S_RUN) begin
          w_se_n         = 1'b1;
          w_shadow_n     = {7{4'hE}};
          w_shadow_err_n = 7'd0;
        end
        if (w_idx == 3'd0) begin
          w_shadow_n[0]     = w_dec[3:0];
          w_shadow_err_n[0] = w_dec[4];
          w_expect_n        = 3'd1;
          w_state_n         = S_RUN;
        end else begin
          w_state_n = S_SYNC;
        end
      end else if (w_idx == 3'd7) begin
        w_digits_n = {w_dec[3:0], r_shadow};
        w_derr_n   = {w_dec[4], r_shadow_err};
        w_fv_n     = 1'b1;
        w_expect_n = 3'd0;
      end else begin
        w_shadow_n[w_idx]     = w_dec[3:0];
        w_shadow_err_n[w_idx] = w_dec[4];
        w_expect_n            = r_expect + 3'd1;
      end
    end

    // stall is evaluated after the capture so it wins the state
    if (w_sel_change) begin
      w_stall_cnt_n = '0;
      w_stall_n     = 1'b0;
    end else if (r_stall_cnt != STALL_MAX) begin
      w_stall_cnt_n = r_stall_cnt + SW'(1);
      if (w_stall_cnt_n == STALL_MAX) begin
        w_stall_n = 1'b1;
        w_state_n = S_SYNC;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_seg         <= 7'h7F;
      r_seg_p       <= 7'h7F;
      r_sel         <= 8'hFF;
      r_sel_p       <= 8'hFF;
      r_settle      <= 4'd0;
      r_stall_cnt   <= '0;
      r_stall       <= 1'b0;
      r_state       <= S_SYNC;
      r_expect      <= 3'd0;
      r_shadow      <= {7{4'hE}};
      r_shadow_err  <= 7'd0;
      o_digits_bcd  <= 32'hEEEE_EEEE;
      o_digit_err   <= 8'd0;
      r_fv          <= 1'b0;
      r_se          <= 1'b0;
    end else if (i_ce) begin
      r_seg         <= i_seg_in;
      r_seg_p       <= r_seg;
      r_sel         <= i_sel_in;
      r_sel_p       <= r_sel;
      r_settle      <= w_settle_n;
      r_stall_cnt   <= w_stall_cnt_n;
      r_stall       <= w_stall_n;
      r_state       <= w_state_n;
      r_expect      <= w_expect_n;
      r_shadow      <= w_shadow_n;
      r_shadow_err  <= w_shadow_err_n;
      o_digits_bcd  <= w_digits_n;
      o_digit_err   <= w_derr_n;
      r_fv          <= w_fv_n;
      r_se          <= w_se_n;
    end else begin
      r_fv <= 1'b0;
      r_se <= 1'b0;
    end
  end

  assign o_frame_valid = r_fv;
  assign o_seq_err     = r_se;
  assign o_stall       = r_stall;
  assign o_locked      = (r_state == S_RUN);

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Scoreboard bench for seven_seg_scan_decoder: expected frames are queued as
// scans are driven and popped by a monitor on each frame_valid pulse.
module tb_seven_seg_scan_decoder;

  logic        clk = 1'b0;
  logic        clr, ce;
  logic [6:0]  seg;
  logic [7:0]  sel;
  logic [31:0] digits;
  logic [7:0]  derr;
  logic        fv, se, stall, locked;

  seven_seg_scan_decoder #(.SETTLE(2), .STALL_CYCLES(1024)) dut (
    .i_clk(clk), .i_clr(clr), .i_ce(ce), .i_seg_in(seg), .i_sel_in(sel),
    .o_digits_bcd(digits), .o_digit_err(derr), .o_frame_valid(fv),
    .o_seq_err(se), .o_stall(stall), .o_locked(locked)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] d; logic [7:0] e; } exp_t;
  exp_t q[$];

  int n_tests = 0, n_fail = 0;
  int n_frames = 0, n_seq = 0;
  int cyc_cnt = 0, last_fv = 0, fv_gap = 0;
  logic prev_fv = 1'b0;
  logic [6:0] segs [10];
  logic [7:0][6:0] p_norm;

  // monitor: pops the scoreboard on every frame pulse
  always @(negedge clk) begin
    exp_t e;
    cyc_cnt++;
    if (fv) begin
      n_frames++;
      fv_gap  = cyc_cnt - last_fv;
      last_fv = cyc_cnt;
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL frame_unexpected: got digits=%h err=%h, none expected", digits, derr);
      end else begin
        e = q.pop_front();
        if (digits !== e.d || derr !== e.e) begin
          n_fail++;
          $display("FAIL frame_data: got digits=%h err=%h, want digits=%h err=%h",
                   digits, derr, e.d, e.e);
        end
      end
      n_tests++;
      if (prev_fv !== 1'b0) begin
        n_fail++;
        $display("FAIL fv_pulse_width: frame_valid high on consecutive cycles, want single pulse");
      end
    end
    if (se) n_seq++;
    prev_fv = fv;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic show(input int k, input logic [6:0] s, input int dwell);
    sel = (k < 0) ? 8'hFF : ~(8'h01 << k);
    seg = s;
    cyc(dwell);
  endtask

  task automatic scan(input logic [7:0][6:0] p, input int from, input int to);
    for (int k = from; k <= to; k++) show(k, p[k], 4);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic test_reset();
    clr = 1'b1; ce = 1'b1; sel = 8'hFF; seg = 7'h7F;
    cyc(3);
    n_tests += 6;
    if (digits !== 32'hEEEE_EEEE) begin n_fail++; $display("FAIL rst_digits: got %h want eeeeeeee", digits); end
    if (derr !== 8'h00)   begin n_fail++; $display("FAIL rst_err: got %h want 00", derr); end
    if (fv !== 1'b0)      begin n_fail++; $display("FAIL rst_fv: got %b want 0", fv); end
    if (se !== 1'b0)      begin n_fail++; $display("FAIL rst_seq: got %b want 0", se); end
    if (stall !== 1'b0)   begin n_fail++; $display("FAIL rst_stall: got %b want 0", stall); end
    if (locked !== 1'b0)  begin n_fail++; $display("FAIL rst_locked: got %b want 0", locked); end
    clr = 1'b0;
    cyc(2);
  endtask

  task automatic test_basic();
    int f0 = n_frames, s0 = n_seq;
    scan(p_norm, 5, 7);
    chk("midframe_ignored", 32'(n_frames), 32'(f0));
    chk("midframe_unlocked", 32'(locked), 32'd0);
    for (int r = 0; r < 2; r++) begin
      q.push_back('{32'h8765_4321, 8'h00});
      scan(p_norm, 0, 7);
    end
    show(-1, 7'h7F, 4);
    chk("basic_frames", 32'(n_frames), 32'(f0 + 2));
    chk("basic_gap", 32'(fv_gap), 32'd32);
    chk("basic_locked", 32'(locked), 32'd1);
    chk("basic_noseq", 32'(n_seq), 32'(s0));
  endtask

  task automatic test_errpat();
    logic [7:0][6:0] p = p_norm;
    int f0 = n_frames;
    p[2] = 7'b0101010;
    p[4] = 7'b1111111;
    q.push_back('{32'h876E_4F21, 8'h04});
    scan(p, 0, 7);
    show(-1, 7'h7F, 4);
    chk("errpat_frames", 32'(n_frames), 32'(f0 + 1));
  endtask

  task automatic test_skip();
    int f0 = n_frames, s0 = n_seq;
    scan(p_norm, 0, 2);
    show(4, p_norm[4], 4);
    chk("skip_seq", 32'(n_seq), 32'(s0 + 1));
    chk("skip_unlocked", 32'(locked), 32'd0);
    scan(p_norm, 5, 7);
    chk("skip_noframe", 32'(n_frames), 32'(f0));
    q.push_back('{32'h8765_4321, 8'h00});
    scan(p_norm, 0, 7);
    show(-1, 7'h7F, 4);
    chk("skip_resume", 32'(n_frames), 32'(f0 + 1));
    chk("skip_seq_once", 32'(n_seq), 32'(s0 + 1));
  endtask

  task automatic test_short_dwell();
    int f0 = n_frames, s0 = n_seq;
    scan(p_norm, 0, 1);
    show(2, p_norm[2], 1);
    show(3, p_norm[3], 4);
    chk("short_dwell_seq", 32'(n_seq), 32'(s0 + 1));
    chk("short_dwell_unlocked", 32'(locked), 32'd0);
    sel = 8'b1111_1100; seg = p_norm[0];
    cyc(4);
    chk("two_low_seq", 32'(n_seq), 32'(s0 + 2));
    q.push_back('{32'h8765_4321, 8'h00});
    scan(p_norm, 0, 7);
    show(-1, 7'h7F, 4);
    chk("short_dwell_recover", 32'(n_frames), 32'(f0 + 1));
  endtask

  task automatic test_stall();
    int s0 = n_seq;
    int w = 0;
    show(0, p_norm[0], 1010);
    chk("stall_early", 32'(stall), 32'd0);
    while (stall !== 1'b1 && w < 60) begin cyc(1); w++; end
    chk("stall_set", 32'(stall), 32'd1);
    chk("stall_unlocked", 32'(locked), 32'd0);
    chk("stall_noseq", 32'(n_seq), 32'(s0));
    show(1, p_norm[1], 3);
    chk("stall_clear", 32'(stall), 32'd0);
    show(-1, 7'h7F, 4);
  endtask

  task automatic test_clr_ce();
    int f0;
    scan(p_norm, 0, 4);
    clr = 1'b1;
    cyc(1);
    chk("clr_digits", digits, 32'hEEEE_EEEE);
    chk("clr_err", 32'(derr), 32'd0);
    chk("clr_locked", 32'(locked), 32'd0);
    chk("clr_fv", 32'(fv), 32'd0);
    clr = 1'b0;
    show(-1, 7'h7F, 2);
    scan(p_norm, 0, 3);
    f0 = n_frames;
    ce = 1'b0;
    for (int i = 0; i < 50; i++) begin
      sel = 8'($urandom);
      seg = 7'($urandom);
      cyc(1);
    end
    chk("ce_locked_hold", 32'(locked), 32'd1);
    chk("ce_digits_hold", digits, 32'hEEEE_EEEE);
    chk("ce_noframe", 32'(n_frames), 32'(f0));
    sel = ~8'h10; seg = p_norm[4];
    ce = 1'b1;
    q.push_back('{32'h8765_4321, 8'h00});
    scan(p_norm, 4, 7);
    show(-1, 7'h7F, 4);
    chk("ce_resume_frame", 32'(n_frames), 32'(f0 + 1));
  endtask

  initial begin
    segs = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
             7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    for (int k = 0; k < 8; k++) p_norm[k] = segs[k + 1];
    clr = 1'b1; ce = 1'b1; sel = 8'hFF; seg = 7'h7F;
    test_reset();
    test_basic();
    test_errpat();
    test_skip();
    test_short_dwell();
    test_stall();
    test_clr_ce();
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_decoder.md
Name: seven_seg_scan_decoder

Overview:
Receive-side counterpart of the multiplexed seven-segment driver. Monitors the scanned segment/select bus (seg_out/seg_select) and reconstructs the eight displayed digits as BCD. Checks scan order and segment validity. Used as an on-chip self-check monitor and as a bench scoreboard front-end for the chess-clock display path.

Parameters:
SETTLE, 2, consecutive CE cycles with unchanged seg_in and sel_in required before a digit is captured (1..15)
STALL_CYCLES, 1024, CE cycles with unchanged sel_in before stall is flagged (width of stall counter = clog2(STALL_CYCLES)+1)

Ports:
CLK  in  1  system clock; all logic on rising edge
CLR  in  1  synchronous, active-high reset
CE  in  1  clock enable; all state advances only when CE=1
seg_in  in  7  segment bus, active-low, bit0=a … bit6=g
sel_in  in  8  digit select, active-low one-cold, bit0=digit1 … bit7=digit8
digits_bcd  out  32  decoded frame, digit k (1..8) at [4k-1:4k-4]
digit_err  out  8  per-digit unrecognised pattern flag for last committed frame
frame_valid  out  1  one-cycle pulse when digits_bcd/digit_err update
seq_err  out  1  one-cycle pulse on scan-order or select-format violation
stall  out  1  level; scan frozen for STALL_CYCLES
locked  out  1  level; high in RUN state

Behaviour:
- Reset (CLR=1 at edge, overrides CE): digits_bcd=32'hEEEE_EEEE, digit_err=0, frame_valid=0, seq_err=0, stall=0, locked=0, state=SYNC, settle/stall counters=0, shadow regs=blank.
- CE=0: all registers hold; frame_valid and seq_err forced 0 that cycle.
- Input register stage: seg_in/sel_in sampled into registers every CE cycle; all comparisons use registered values (1-cycle input latency).
- Settle counter: increments while registered seg/sel equal previous sample; reset to 1 on any change. Capture event when counter reaches exactly SETTLE; at most one capture per dwell.
- Select format: exactly one bit low is valid; index = position of the low bit. All-high (blanking gap) is ignored, no capture, not an error. Two or more bits low at a capture point -> seq_err pulse, state -> SYNC.
- Decode (active-low): 1000000->0, 1111001->1, 0100100->2, 0110000->3, 0011001->4, 0010010->5, 0000010->6, 1111000->7, 0000000->8, 0010000->9, 1111111->E (blank), anything else ->F plus shadow error bit set.
- FSM:
  SYNC: ignore captures until index 0 is captured; store into shadow[0], expect=1, -> RUN.
  RUN: capture with index==expect -> store shadow[index], expect=expect+1 mod 8. Capture with index!=expect -> seq_err pulse, discard shadow, -> SYNC; if that index is 0, it is consumed as a fresh SYNC start (shadow[0] stored, expect=1, -> RUN).
  Index-7 capture in RUN: on that same edge digits_bcd <= shadow[0..6] plus decoded digit 8; digit_err likewise; frame_valid=1 for one cycle; expect=0, remain RUN (continuous frames).
- Stall: counter of CE cycles with unchanged registered sel_in; at STALL_CYCLES, stall=1 and state -> SYNC (no seq_err). stall clears on the cycle sel_in changes. Counter saturates.
- Outputs change only at commit; partial frames never visible.
- Simultaneous stall threshold and capture: capture processed first, then stall transition.

Test Plan:
- Driver-style scan, CE=1, dwell 4 cycles, sel ascending bit0..bit7, seg=1,2,3,4,5,6,7,8 patterns, starting mid-frame at index 5 -> indices 5..7 ignored; after next index 7, digits_bcd=32'h8765_4321, digit_err=0, frame_valid single pulse, locked=1; repeats once per 32 cycles.
- Skip index 3 in RUN -> seq_err one pulse at index-4 capture, locked=0, no frame_valid; resumes and commits after next complete 0..7 pass.
- digit3 pattern 0101010, digit5 blank 1111111 -> digits_bcd=32'h876E_4F21, digit_err=8'h04.
- Dwell of 1 cycle on index 2 with SETTLE=2 -> index 2 not captured, index-3 capture gives seq_err; two bits low (sel=8'b1111_1100) -> seq_err.
- Hold sel constant for 1024 CE cycles -> stall=1, locked=0; next sel change -> stall=0.
- CLR asserted after index 4 capture -> next edge all outputs at reset values; CE=0 for 50 cycles mid-frame -> no state change, frame completes normally after CE returns.
